// File: rtl/writeback_stage_pkg.sv
// definitions: shared result-source enum, load funct3 codes, W-register layout and clock period
package definitions;
  localparam int CLOCK_PERIOD = 10;
  typedef enum logic [1:0] {RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10} result_src_t;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  typedef struct packed {
    logic        valid;
    logic        reg_w_en;
    logic [4:0]  addr;
    logic [1:0]  src;
    logic [2:0]  funct3;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] raw;
  } w_reg_t;
endpackage

// File: rtl/writeback_stage_load_formatter.sv
// load_formatter: byte/half extraction with sign/zero extension of a raw load word (in Raw, Funct3, Offset; out Data)
module load_formatter
  import definitions::*;
(
  input  logic [31:0] Raw,
  input  logic [2:0]  Funct3,
  input  logic [1:0]  Offset,
  output logic [31:0] Data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b    = 8'(Raw >> {Offset, 3'b000});
    h    = Offset[1] ? Raw[31:16] : Raw[15:0];
    Data = Funct3 == F3_LB  ? {{24{b[7]}}, b}  :
           Funct3 == F3_LBU ? {24'b0, b}       :
           Funct3 == F3_LH  ? {{16{h[15]}}, h} :
           Funct3 == F3_LHU ? {16'b0, h}       : Raw;
  end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB register, load formatting, result mux, regfile write port and retire report (in CLK,RST,STALL,FLUSH,M_*; out REG_W_*,WB_Retire,Instret; RETIRE_COUNTER_EN enables the 64-bit Instret counter)
module writeback_stage
  import definitions::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic        M_Valid,
  input  logic        M_REG_W_En,
  input  logic [4:0]  M_REG_W_Addr,
  input  logic [1:0]  M_Result_Src,
  input  logic [2:0]  M_Funct3,
  input  logic [31:0] M_ALU_Result,
  input  logic [31:0] M_PC_Plus_4,
  input  logic [31:0] M_Load_Data,
  output logic        REG_W_En,
  output logic [4:0]  REG_W_Addr,
  output logic [31:0] REG_W_Data,
  output logic        WB_Retire,
  output logic [63:0] Instret
);
  w_reg_t      w_q, w_d;
  logic [31:0] load_data;
  always_comb begin
    w_d = STALL ? w_q : '{M_Valid, M_REG_W_En, M_REG_W_Addr, M_Result_Src, M_Funct3,
                          M_ALU_Result, M_PC_Plus_4, M_Load_Data};
    if (FLUSH) begin
      w_d.valid    = 1'b0;
      w_d.reg_w_en = 1'b0;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) w_q <= '0;
    else     w_q <= w_d;
  end
  load_formatter u_fmt (
    .Raw    (w_q.raw),
    .Funct3 (w_q.funct3),
    .Offset (w_q.alu[1:0]),
    .Data   (load_data)
  );
  assign REG_W_Addr = w_q.addr;
  assign REG_W_Data = w_q.src == RES_MEM ? load_data :
                      w_q.src == RES_PC4 ? w_q.pc4   : w_q.alu;
  assign REG_W_En   = w_q.valid & w_q.reg_w_en & (|w_q.addr) & ~STALL;
  assign WB_Retire  = w_q.valid & ~STALL;
`ifdef RETIRE_COUNTER_EN
  logic [63:0] instret_q, instret_d;
  assign instret_d = instret_q + 64'(WB_Retire);
  always_ff @(posedge CLK) begin
    if (RST) instret_q <= '0;
    else     instret_q <= instret_d;
  end
  assign Instret = instret_q;
`else
  assign Instret = '0;
`endif
endmodule
